candy_vend_ctrl: RTL
====================

Name: candy_vend_ctrl

Overview:
Central sequencing FSM of the candy vending system. Accepts decoded single-cycle coin and button events from the keypad decoder, keeps the customer credit, and grants a vend when credit covers the selected candy price. It then returns change coin-by-coin through a handshake with the coin ejector. It drives the can_buy indicators and the credit value shown on the display mux.

Parameters:
CREDIT_MAX, 15, credit ceiling in 100-unit coins (legal 5..15; credit register is 4 bits).
VEND_CYCLES, 4, cycles the candy strobe is held high per vend (legal 1..15).

Ports:
clk  in  1  system clock; all state on rising edge.
reset  in  1  synchronous, active-high; sampled on rising clk.
coin_100  in  1  one-cycle pulse: 100 coin inserted.
coin_500  in  1  one-cycle pulse: 500 coin inserted.
sel  in  5  one-hot candy select, sampled only with buy; price of sel[i] = i+1 units.
buy  in  1  one-cycle pulse: vend request.
cancel  in  1  one-cycle pulse: return all credit.
eject_ack  in  1  ejector acknowledge; high for >=1 cycle when the coin has left.
credit  out  4  current credit in 100 units.
can_buy  out  5  bit i = 1 when credit >= i+1 and state is IDLE or CREDIT.
candy  out  1  vend strobe.
eject_100  out  1  level request: eject one 100 coin.
eject_500  out  1  level request: eject one 500 coin.
coin_reject  out  1  one-cycle pulse: inserted coin is not accepted and is routed to the return chute.
deny  out  1  one-cycle pulse: buy refused.
busy  out  1  high in VEND and CHANGE.

Behaviour:
- Reset: state IDLE; credit=0; can_buy=0; candy=0; eject_100=0; eject_500=0; coin_reject=0; deny=0; busy=0; vend counter=0. Reset mid-vend or mid-change aborts immediately. Credit is lost; outputs return to reset values on the next edge.
- All outputs are registered. An event sampled at edge N takes effect on outputs after edge N.
- States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
- Event priority in IDLE/CREDIT: cancel > buy > coin.
  - A coin pulse in the same cycle as an accepted cancel or buy is rejected (coin_reject).
  - coin_100 and coin_500 high together: both rejected, single coin_reject pulse.
- Coin, IDLE/CREDIT: new = credit + 1 or + 5.
  - new <= CREDIT_MAX: credit=new; state CREDIT.
  - Otherwise: credit unchanged, coin_reject pulse.
- Coins during VEND/CHANGE: always coin_reject; credit unchanged.
- Buy, IDLE/CREDIT:
  - sel must be exactly one-hot and credit >= price. Then credit -= price, state VEND, candy=1 for exactly VEND_CYCLES cycles.
  - Otherwise: deny pulse, state unchanged.
  - cancel or buy in VEND/CHANGE: ignored, no deny.
- VEND exit: after the last candy cycle, go to CHANGE if credit>0, else IDLE.
- Cancel, IDLE/CREDIT: CHANGE if credit>0. In IDLE, cancel is a no-op.
- CHANGE (greedy):
  - With no request pending: if credit>=5 assert eject_500, else assert eject_100.
  - Hold the request until eject_ack is sampled high. Then deassert it and decrement credit by 5 or 1 on that edge.
  - The next request is issued no earlier than one cycle after deassert (at least one low cycle between requests).
  - When credit reaches 0, go to IDLE.
  - eject_ack while no request is pending is ignored.
- eject_100 and eject_500 are never high together. candy is never high in CHANGE.
- can_buy is recomputed from the registered credit each cycle and forced to 0 in VEND/CHANGE.
- busy = (state==VEND || state==CHANGE).

Test Plan:
- Reset, then two coin_100 pulses, then buy with sel=00010 -> credit 1 then 2, can_buy=00011; candy high 4 cycles; credit=0; state IDLE; no eject.
- coin_500, then buy with sel=00100 -> credit 5, can_buy=11111; after vend credit=2; CHANGE issues eject_100 twice, each held until ack (ack returned 3 cycles after request); final credit 0.
- Three coin_500 pulses, then coin_100 -> credit 15; the fourth coin gives a coin_reject pulse; credit stays 15. Then cancel -> eject_500 x3 in order, IDLE.
- With credit=1, buy with sel=01000 -> deny pulse, credit 1. sel=00011 -> deny. coin_100 and buy(sel=00001) in the same cycle -> vend, coin_reject, credit 0.
- coin_100 pulsed during VEND and during CHANGE -> coin_reject each time; credit sequence unaffected.
- reset asserted while eject_500 is waiting for ack -> next cycle all outputs 0, credit 0, IDLE; a later ack is ignored.

Source files
------------

// File: rtl/candy_vend_ctrl.sv
// Candy vending sequencer: keeps customer credit, grants vends, and returns
// change coin-by-coin through a request/acknowledge handshake with the ejector.
module candy_vend_ctrl #(
  parameter int unsigned CREDIT_MAX  = 15,
  parameter int unsigned VEND_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic [4:0] sel,
  input  logic       buy,
  input  logic       cancel,
  input  logic       eject_ack,
  output logic [3:0] credit,
  output logic [4:0] can_buy,
  output logic       candy,
  output logic       eject_100,
  output logic       eject_500,
  output logic       coin_reject,
  output logic       deny,
  output logic       busy
);

  localparam int unsigned CW = 4;
  localparam logic [CW:0]   CMAX  = (CW+1)'(CREDIT_MAX);
  localparam logic [CW-1:0] VC_M1 = CW'(VEND_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt, cnt, cnt_nxt;
  logic [4:0]    can_buy_nxt;
  logic          candy_nxt, e100_nxt, e500_nxt, rej_nxt, deny_nxt, busy_nxt;
  logic          coin_any, coin_both, buy_ok, take_cancel, ready_nxt;
  logic [2:0]    price;
  logic [CW:0]   coin_sum;

  // Price of the selected candy; only meaningful when sel is one-hot
  always_comb begin
    price = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (sel[i]) price = 3'(i + 1);
    end
  end

  assign coin_any    = coin_100 | coin_500;
  assign coin_both   = coin_100 & coin_500;
  assign coin_sum    = {1'b0, credit} + (coin_500 ? (CW+1)'(5) : (CW+1)'(1));
  assign buy_ok      = $onehot(sel) && (credit >= {1'b0, price});
  assign take_cancel = cancel && (credit != '0);

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    cnt_nxt    = cnt;
    candy_nxt  = 1'b0;
    e100_nxt   = 1'b0;
    e500_nxt   = 1'b0;
    rej_nxt    = 1'b0;
    deny_nxt   = 1'b0;
    case (state)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          if (take_cancel) state_nxt = S_CHANGE;
        end else if (buy) begin
          if (buy_ok) begin
            credit_nxt = credit - {1'b0, price};
            state_nxt  = S_VEND;
            cnt_nxt    = VC_M1;
            candy_nxt  = 1'b1;
          end else begin
            deny_nxt = 1'b1;
          end
        end
        // A coin is only banked when no cancel/buy was taken this cycle
        if (coin_any) begin
          if (take_cancel || (!cancel && buy && buy_ok) || coin_both || (coin_sum > CMAX)) begin
            rej_nxt = 1'b1;
          end else begin
            credit_nxt = coin_sum[CW-1:0];
            state_nxt  = S_CREDIT;
          end
        end
      end
      S_VEND: begin
        rej_nxt = coin_any;
        if (cnt == '0) begin
          state_nxt = (credit != '0) ? S_CHANGE : S_IDLE;
        end else begin
          cnt_nxt   = cnt - CW'(1);
          candy_nxt = 1'b1;
        end
      end
      S_CHANGE: begin
        rej_nxt = coin_any;
        if (eject_100 || eject_500) begin
          if (eject_ack) begin
            credit_nxt = credit - (eject_500 ? CW'(5) : CW'(1));
            if (credit_nxt == '0) state_nxt = S_IDLE;
          end else begin
            e100_nxt = eject_100;
            e500_nxt = eject_500;
          end
        end else if (credit >= CW'(5)) begin
          e500_nxt = 1'b1;
        end else begin
          e100_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Indicators follow the credit and state being registered this edge
  always_comb begin
    ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_CREDIT);
    busy_nxt  = !ready_nxt;
    for (int i = 0; i < 5; i++) begin
      can_buy_nxt[i] = ready_nxt && (credit_nxt >= CW'(i + 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      credit      <= '0;
      cnt         <= '0;
      can_buy     <= '0;
      candy       <= 1'b0;
      eject_100   <= 1'b0;
      eject_500   <= 1'b0;
      coin_reject <= 1'b0;
      deny        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      cnt         <= cnt_nxt;
      can_buy     <= can_buy_nxt;
      candy       <= candy_nxt;
      eject_100   <= e100_nxt;
      eject_500   <= e500_nxt;
      coin_reject <= rej_nxt;
      deny        <= deny_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
